ysyx_22041071_mem: RTL and testbench

YSYX_22041071_MEM -- requirements
Module: ysyx_22041071_MEM

---
 rtl/ysyx_22041071_mem_pkg.sv | 33 +++
 rtl/ysyx_22041071_LSU_fmt.sv | 45 ++++
 rtl/ysyx_22041071_mem.sv | 137 +++++++++++++
 tb/tb_ysyx_22041071_mem.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_mem_pkg.sv
// Shared MEM-stage types: FSM states, funct3 load/store codes and bus widths.
package ysyx_22041071_mem_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int RLEN = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size lives in funct3[1:0] for both signed and unsigned forms.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [2:0] off);
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off[1:0];
            2'b11:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041071_LSU_fmt.sv
// Combinational load extension and store lane alignment for the MEM stage.
module ysyx_22041071_LSU_fmt
    import ysyx_22041071_mem_pkg::*;
(
    input  logic [1:0]      st_size,
    input  logic [2:0]      st_off,
    input  logic [XLEN-1:0] st_data,
    input  logic [2:0]      ld_funct3,
    input  logic [2:0]      ld_off,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] st_wdata,
    output logic [7:0]      st_wmask,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]      size_mask;
    logic [XLEN-1:0] lane;

    always_comb begin
        case (st_size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        // Bytes shifted past lane 7 simply fall off.
        st_wmask = size_mask << st_off;
        st_wdata = st_data << {st_off, 3'b000};
    end

    always_comb begin
        lane = ld_rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{56{lane[7]}}, lane[7:0]};
            F3_H:    ld_data = {{48{lane[15]}}, lane[15:0]};
            F3_W:    ld_data = {{32{lane[31]}}, lane[31:0]};
            F3_D:    ld_data = lane;
            F3_BU:   ld_data = {56'd0, lane[7:0]};
            F3_HU:   ld_data = {48'd0, lane[15:0]};
            F3_WU:   ld_data = {32'd0, lane[31:0]};
            default: ld_data = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_22041071_mem.sv
// MEM pipeline stage: ALU pass-through plus load/store over a req/rvalid bus.
// Define YSYX_22041071_MISALIGN_CHK_EN to add the misalign trap output.
module ysyx_22041071_mem
    import ysyx_22041071_mem_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid5,
    output logic            ready5,
    input  logic [XLEN-1:0] PC5,
    input  logic [ILEN-1:0] Ins4,
    input  logic            MEM_W_en3,
    input  logic            WB_sel3,
    input  logic            reg_w_en3,
    input  logic [XLEN-1:0] rt_data2,
    input  logic [RLEN-1:0] rdest2,
    input  logic [XLEN-1:0] ALU_result1,
    output logic            valid6,
    input  logic            ready6,
    output logic [XLEN-1:0] PC6,
    output logic [ILEN-1:0] Ins5,
    output logic            reg_w_en4,
    output logic [RLEN-1:0] rdest3,
    output logic [XLEN-1:0] WB_data,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_wen,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wmask,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
`ifdef YSYX_22041071_MISALIGN_CHK_EN
    ,
    output logic            misalign
`endif
);

    mem_state_e      state, state_n;
    logic            accept, is_mem, mis, done;
    logic            ld_q;
    logic [2:0]      off_q;
    logic [XLEN-1:0] st_wdata, ld_data;
    logic [7:0]      st_wmask;

    assign ready5         = (state == S_IDLE) && (!valid6 || ready6);
    assign accept         = valid5 && ready5;
    assign is_mem         = MEM_W_en3 || WB_sel3;
    assign dmem_req_valid = (state == S_REQ);
    assign done           = (state == S_WAIT) && dmem_rvalid;

`ifdef YSYX_22041071_MISALIGN_CHK_EN
    assign mis = is_mem && misaligned(Ins4[14:12], ALU_result1[2:0]);
`else
    assign mis = 1'b0;
`endif

    ysyx_22041071_LSU_fmt u_fmt (
        .st_size   (Ins4[13:12]),
        .st_off    (ALU_result1[2:0]),
        .st_data   (rt_data2),
        .ld_funct3 (Ins5[14:12]),
        .ld_off    (off_q),
        .ld_rdata  (dmem_rdata),
        .st_wdata  (st_wdata),
        .st_wmask  (st_wmask),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (accept && is_mem && !mis) state_n = S_REQ;
            S_REQ:   if (dmem_req_ready)           state_n = S_WAIT;
            S_WAIT:  if (dmem_rvalid)              state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Payload is written on acceptance; valid6 is low then, so nothing
    // visible to WB changes while a result is being held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid6     <= 1'b0;
            PC6        <= '0;
            Ins5       <= '0;
            rdest3     <= '0;
            reg_w_en4  <= 1'b0;
            WB_data    <= '0;
            dmem_addr  <= '0;
            dmem_wen   <= 1'b0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
            ld_q       <= 1'b0;
            off_q      <= '0;
        end else begin
            if (valid6 && ready6) valid6 <= 1'b0;
            if (accept) begin
                PC6       <= PC5;
                Ins5      <= Ins4;
                rdest3    <= rdest2;
                reg_w_en4 <= reg_w_en3 && !MEM_W_en3 && !mis;
                if (!is_mem) begin
                    valid6  <= 1'b1;
                    WB_data <= ALU_result1;
                end else if (mis) begin
                    valid6  <= 1'b1;
                    WB_data <= '0;
                end else begin
                    dmem_addr  <= {ALU_result1[XLEN-1:3], 3'b000};
                    dmem_wen   <= MEM_W_en3;
                    dmem_wdata <= MEM_W_en3 ? st_wdata : '0;
                    dmem_wmask <= MEM_W_en3 ? st_wmask : 8'h00;
                    ld_q       <= !MEM_W_en3;
                    off_q      <= ALU_result1[2:0];
                end
            end
            if (done) begin
                valid6  <= 1'b1;
                WB_data <= ld_q ? ld_data : '0;
            end
        end
    end

`ifdef YSYX_22041071_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       misalign <= 1'b0;
        else if (accept) misalign <= mis;
    end
`endif

endmodule

// File: tb/tb_ysyx_22041071_mem.sv
// Scoreboard bench for the MEM stage with a simple handshaking memory model.
module tb_ysyx_22041071_mem;

    logic        clk, reset;
    logic        valid5, ready5;
    logic [63:0] PC5;
    logic [31:0] Ins4;
    logic        MEM_W_en3, WB_sel3, reg_w_en3;
    logic [63:0] rt_data2;
    logic [4:0]  rdest2;
    logic [63:0] ALU_result1;
    logic        valid6, ready6;
    logic [63:0] PC6;
    logic [31:0] Ins5;
    logic        reg_w_en4;
    logic [4:0]  rdest3;
    logic [63:0] WB_data;
    logic        dmem_req_valid, dmem_req_ready;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
`ifdef YSYX_22041071_MISALIGN_CHK_EN
    logic        misalign;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [63:0] data;
        logic        wen;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [63:0] cap_addr, cap_wdata;
    logic [7:0]  cap_mask;
    logic        cap_wen;

    ysyx_22041071_mem dut (
        .clk            (clk),
        .reset          (reset),
        .valid5         (valid5),
        .ready5         (ready5),
        .PC5            (PC5),
        .Ins4           (Ins4),
        .MEM_W_en3      (MEM_W_en3),
        .WB_sel3        (WB_sel3),
        .reg_w_en3      (reg_w_en3),
        .rt_data2       (rt_data2),
        .rdest2         (rdest2),
        .ALU_result1    (ALU_result1),
        .valid6         (valid6),
        .ready6         (ready6),
        .PC6            (PC6),
        .Ins5           (Ins5),
        .reg_w_en4      (reg_w_en4),
        .rdest3         (rdest3),
        .WB_data        (WB_data),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_wen       (dmem_wen),
        .dmem_wdata     (dmem_wdata),
        .dmem_wmask     (dmem_wmask),
        .dmem_rvalid    (dmem_rvalid),
`ifdef YSYX_22041071_MISALIGN_CHK_EN
        .misalign       (misalign),
`endif
        .dmem_rdata     (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ld_model(input logic [2:0] f3,
                                             input logic [2:0] off,
                                             input logic [63:0] rd);
        logic [63:0] v;
        int nb;
        v  = '0;
        nb = 1 << f3[1:0];
        for (int k = 0; k < nb; k++)
            if (int'(off) + k < 8)
                v[8*k +: 8] = rd[8*(int'(off) + k) +: 8];
        if (!f3[2] && nb < 8 && v[8*nb-1])
            for (int k = nb; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic send(input logic [63:0] pc, input logic [2:0] f3,
                        input logic st, input logic ld, input logic rwe,
                        input logic [63:0] alu, input logic [63:0] sd,
                        input logic [4:0] rd);
        int n;
        PC5 = pc;
        Ins4 = {17'd0, f3, 5'd0, 7'h03};
        MEM_W_en3 = st;
        WB_sel3 = ld;
        reg_w_en3 = rwe;
        ALU_result1 = alu;
        rt_data2 = sd;
        rdest2 = rd;
        valid5 = 1'b1;
        n = 0;
        while (!ready5 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!ready5) begin
            errors++;
            $display("FAIL accept_timeout: ready5=%0b required 1", ready5);
        end
        @(posedge clk); #1;
        valid5 = 1'b0;
    endtask

    task automatic serve(input logic [63:0] rdata, input int delay);
        int n;
        n = 0;
        while (!dmem_req_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!dmem_req_valid) begin
            errors++;
            $display("FAIL req_timeout: dmem_req_valid=0 required 1");
            return;
        end
        cap_addr  = dmem_addr;
        cap_mask  = dmem_wmask;
        cap_wdata = dmem_wdata;
        cap_wen   = dmem_wen;
        @(posedge clk); #1;
        checks++;
        if ({dmem_req_valid, dmem_addr, dmem_wmask, dmem_wdata, dmem_wen} !==
            {1'b1, cap_addr, cap_mask, cap_wdata, cap_wen}) begin
            errors++;
            $display("FAIL req_stable: addr=%h mask=%h got, addr=%h mask=%h required",
                     dmem_addr, dmem_wmask, cap_addr, cap_mask);
        end
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        repeat (delay) begin
            @(posedge clk); #1;
        end
        dmem_rdata  = rdata;
        dmem_rvalid = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
    endtask

    task automatic expect_wb(input string name, input int budget);
        exp_t e;
        int n;
        n = 0;
        while (!valid6 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!valid6 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: valid6=%0b pending=%0d, required valid6=1 with entry",
                     name, valid6, sb_q.size());
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (WB_data !== e.data) begin
                errors++;
                $display("FAIL %s_data: got %h required %h", name, WB_data, e.data);
            end
            checks++;
            if ({PC6, rdest3, reg_w_en4} !== {e.pc, e.rd, e.wen}) begin
                errors++;
                $display("FAIL %s_payload: pc=%h rd=%0d wen=%0b required pc=%h rd=%0d wen=%0b",
                         name, PC6, rdest3, reg_w_en4, e.pc, e.rd, e.wen);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({valid6, dmem_req_valid, dmem_wen, reg_w_en4} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000",
                     {valid6, dmem_req_valid, dmem_wen, reg_w_en4});
        end
        checks++;
        if ({PC6, Ins5, rdest3, WB_data, dmem_addr, dmem_wdata, dmem_wmask} !== '0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h wb=%h addr=%h mask=%h required all 0",
                     PC6, WB_data, dmem_addr, dmem_wmask);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready5 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready5: got %b required 1", ready5);
        end
    endtask

    task automatic test_alu();
        sb_q.push_back('{64'h100, 64'h1234, 1'b1, 5'd7});
        send(64'h100, 3'b000, 1'b0, 1'b0, 1'b1, 64'h1234, 64'h0, 5'd7);
        expect_wb("alu", 0);
        checks++;
        if (ready5 !== 1'b1) begin
            errors++;
            $display("FAIL alu_ready5: got %b required 1", ready5);
        end
        @(posedge clk); #1;
        checks++;
        if (valid6 !== 1'b0) begin
            errors++;
            $display("FAIL alu_clear: valid6=%b required 0", valid6);
        end
    endtask

    task automatic test_lb_req();
        sb_q.push_back('{64'h200, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 5'd3});
        send(64'h200, 3'b000, 1'b0, 1'b1, 1'b1, 64'h8000_1003, 64'h0, 5'd3);
        serve(64'h0000_0000_8000_0000, 2);
        checks++;
        if (cap_addr !== 64'h8000_1000 || cap_wen !== 1'b0) begin
            errors++;
            $display("FAIL lb_addr: addr=%h wen=%b required 8000_1000/0",
                     cap_addr, cap_wen);
        end
        expect_wb("lb", 0);
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [7];
        logic [2:0]  offs [7];
        logic [63:0] rdata, addr;
        f3s   = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3};
        offs  = '{3'd7, 3'd1, 3'd2, 3'd6, 3'd4, 3'd0, 3'd0};
        rdata = 64'hF1E2_D3C4_B5A6_9788;
        for (int i = 0; i < 7; i++) begin
            addr = 64'h9000_2000 | 64'(offs[i]);
            sb_q.push_back('{64'h400 + 64'(4*i), ld_model(f3s[i], offs[i], rdata),
                             1'b1, 5'(i + 1)});
            send(64'h400 + 64'(4*i), f3s[i], 1'b0, 1'b1, 1'b1, addr, 64'h0, 5'(i + 1));
            serve(rdata, i % 3);
            expect_wb("load", 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stores();
        logic [2:0]  offs [4];
        logic [63:0] datas [4];
        logic [7:0]  m;
        logic [63:0] addr;
        offs  = '{3'd5, 3'd6, 3'd4, 3'd0};
        datas = '{64'h5555_0000_0000_00AB, 64'h0000_0000_0000_ABCD,
                  64'h0000_0000_1122_3344, 64'h0102_0304_0506_0708};
        for (int sz = 0; sz < 4; sz++) begin
            addr = 64'hA000_0000 | 64'(offs[sz]);
            m = 8'h00;
            for (int k = 0; k < (1 << sz); k++)
                if (int'(offs[sz]) + k < 8) m[int'(offs[sz]) + k] = 1'b1;
            sb_q.push_back('{64'h500, 64'h0, 1'b0, 5'd9});
            send(64'h500, 3'(sz), 1'b1, 1'b0, 1'b1, addr, datas[sz], 5'd9);
            serve(64'hDEAD_BEEF_DEAD_BEEF, 1);
            checks++;
            if (cap_mask !== m || cap_wen !== 1'b1 ||
                cap_wdata !== (datas[sz] << (8 * int'(offs[sz])))) begin
                errors++;
                $display("FAIL store_bus: mask=%h wdata=%h wen=%b required mask=%h wdata=%h wen=1",
                         cap_mask, cap_wdata, cap_wen, m,
                         datas[sz] << (8 * int'(offs[sz])));
            end
            if (sz == 1) begin
                checks++;
                if (cap_mask !== 8'hC0 || cap_wdata[63:48] !== 16'hABCD) begin
                    errors++;
                    $display("FAIL sh_lane: mask=%h hi=%h required C0/ABCD",
                             cap_mask, cap_wdata[63:48]);
                end
            end
            expect_wb("store", 0);
            @(posedge clk); #1;
        end
        sb_q.push_back('{64'h600, 64'h0, 1'b0, 5'd4});
        send(64'h600, 3'b000, 1'b1, 1'b1, 1'b1, 64'hA000_0001, 64'h77, 5'd4);
        serve(64'h1111_2222_3333_4444, 0);
        checks++;
        if (cap_wen !== 1'b1 || cap_mask !== 8'h02) begin
            errors++;
            $display("FAIL st_ld_flag: wen=%b mask=%h required 1/02", cap_wen, cap_mask);
        end
        expect_wb("st_ld", 0);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [63:0] hold;
        hold = ld_model(3'd2, 3'd0, 64'h0000_0000_8765_4321);
        sb_q.push_back('{64'h700, hold, 1'b1, 5'd12});
        send(64'h700, 3'd2, 1'b0, 1'b1, 1'b1, 64'hB000_0008, 64'h0, 5'd12);
        ready6 = 1'b0;
        serve(64'h0000_0000_8765_4321, 1);
        PC5 = 64'h800;
        Ins4 = 32'h0000_0013;
        MEM_W_en3 = 1'b0;
        WB_sel3 = 1'b0;
        reg_w_en3 = 1'b1;
        ALU_result1 = 64'h5555;
        rdest2 = 5'd13;
        valid5 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (valid6 !== 1'b1 || WB_data !== hold || ready5 !== 1'b0 ||
                PC6 !== 64'h700) begin
                errors++;
                $display("FAIL bp_hold: v6=%b wb=%h r5=%b pc=%h required 1/%h/0/700",
                         valid6, WB_data, ready5, PC6, hold);
            end
        end
        expect_wb("bp_load", 0);
        sb_q.push_back('{64'h800, 64'h5555, 1'b1, 5'd13});
        ready6 = 1'b1;
        @(posedge clk); #1;
        valid5 = 1'b0;
        expect_wb("bp_next", 0);
        @(posedge clk); #1;
        checks++;
        if (valid6 !== 1'b0) begin
            errors++;
            $display("FAIL bp_clear: valid6=%b required 0", valid6);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            PC5 = 64'h900 + 64'(4*i);
            Ins4 = 32'h0000_0033;
            MEM_W_en3 = 1'b0;
            WB_sel3 = 1'b0;
            reg_w_en3 = 1'b1;
            ALU_result1 = 64'hC0DE_0000 + 64'(i * 17);
            rdest2 = 5'(20 + i);
            valid5 = 1'b1;
            sb_q.push_back('{PC5, ALU_result1, 1'b1, rdest2});
            @(posedge clk); #1;
            expect_wb("b2b", 0);
        end
        valid5 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (valid6 !== 1'b0 || ready5 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: valid6=%b ready5=%b required 0/1", valid6, ready5);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        send(64'hA00, 3'd3, 1'b0, 1'b1, 1'b1, 64'hC000_0000, 64'h0, 5'd5);
        n = 0;
        while (!dmem_req_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({valid6, dmem_req_valid, dmem_wen} !== 3'b0 ||
            {PC6, WB_data, dmem_addr, dmem_wmask} !== '0) begin
            errors++;
            $display("FAIL mid_reset: v6=%b req=%b pc=%h addr=%h required all 0",
                     valid6, dmem_req_valid, PC6, dmem_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_rdata = 64'h1234_5678_9ABC_DEF0;
        dmem_rvalid = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        checks++;
        if (valid6 !== 1'b0 || ready5 !== 1'b1 || WB_data !== 64'h0) begin
            errors++;
            $display("FAIL late_rvalid: v6=%b r5=%b wb=%h required 0/1/0",
                     valid6, ready5, WB_data);
        end
    endtask

    task automatic test_idle_ignore();
        dmem_rvalid = 1'b1;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_req_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (valid6 !== 1'b0 || dmem_req_valid !== 1'b0 || ready5 !== 1'b1) begin
            errors++;
            $display("FAIL idle_ignore: v6=%b req=%b r5=%b required 0/0/1",
                     valid6, dmem_req_valid, ready5);
        end
    endtask

`ifdef YSYX_22041071_MISALIGN_CHK_EN
    task automatic test_misalign();
        sb_q.push_back('{64'hB00, 64'h0, 1'b0, 5'd6});
        send(64'hB00, 3'd2, 1'b0, 1'b1, 1'b1, 64'hD000_0002, 64'h0, 5'd6);
        checks++;
        if (misalign !== 1'b1 || dmem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign: mis=%b req=%b required 1/0",
                     misalign, dmem_req_valid);
        end
        expect_wb("misalign", 0);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        valid5 = 1'b0;
        PC5 = '0;
        Ins4 = '0;
        MEM_W_en3 = 1'b0;
        WB_sel3 = 1'b0;
        reg_w_en3 = 1'b0;
        rt_data2 = '0;
        rdest2 = '0;
        ALU_result1 = '0;
        ready6 = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_lb_req();
        test_loads();
        test_stores();
        test_backpressure();
        test_back_to_back();
        test_idle_ignore();
`ifdef YSYX_22041071_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
